// File: rtl/ff_net_core.sv
// Two-layer feed-forward net (inputs -> hidden -> outputs) with hard-sigmoid activations behind a register bus.
// Optional FF_NET_READBACK_EN makes weights and input registers readable over the bus.
module ff_net_core #(
   parameter int LENGHT_I   = 2,
   parameter int LENGHT_MID = 2,
   parameter int LENGHT_O   = 2,
   parameter int WIDTH      = 4,
   parameter int WIDTH_I    = 1,
   parameter int RANGE_SIGM = 16,
   parameter int WIDTH_MID  = $clog2(RANGE_SIGM),
   parameter int WIDTH_O    = $clog2(RANGE_SIGM),
   parameter int WIDTH_W    = 4,
   parameter int WIDTH_ADDR = $clog2(LENGHT_I*LENGHT_MID + LENGHT_MID*LENGHT_O + LENGHT_I + LENGHT_O + 3)
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [WIDTH-1:0]                    in_d,
   input  logic [WIDTH_ADDR-1:0]               address,
   input  logic                                read,
   input  logic                                write,
   output logic [WIDTH-1:0]                    out_d,
   output logic                                ready,
   output logic                                down,
   output logic [LENGHT_I-1:0][WIDTH_I-1:0]    reg_i,
   output logic [LENGHT_MID-1:0][WIDTH_MID-1:0] mid_neiron,
   output logic [LENGHT_O-1:0][WIDTH_O-1:0]    reg_o
);

   localparam int NW1    = LENGHT_I * LENGHT_MID;
   localparam int NW2    = LENGHT_MID * LENGHT_O;
   localparam int NW     = NW1 + NW2;
   localparam int A_CTRL = NW;
   localparam int A_IN   = NW + 1;
   localparam int A_RUN  = NW + LENGHT_I + 1;
   localparam int A_OUT  = A_RUN + 1;
   localparam int A_STAT = A_OUT + LENGHT_O;
   localparam int LMAX   = (LENGHT_I > LENGHT_MID) ? LENGHT_I : LENGHT_MID;
   localparam int XW     = (WIDTH_I > WIDTH_MID) ? WIDTH_I : WIDTH_MID;
   // Sum width covers the largest product times the longest fan-in plus the bias headroom.
   localparam int SW     = WIDTH_W + XW + $clog2(LMAX) + 3;
   localparam int SIG_W  = $clog2(RANGE_SIGM);
   localparam logic signed [SW-1:0] HALF = SW'(RANGE_SIGM / 2);
   localparam logic signed [SW-1:0] MAXV = SW'(RANGE_SIGM - 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC_MID, S_CALC_OUT, S_DONE} state_t;

   state_t                                state_q, state_d;
   logic [WIDTH_W-1:0]                    w1_q [NW1];
   logic [WIDTH_W-1:0]                    w1_d [NW1];
   logic [WIDTH_W-1:0]                    w2_q [NW2];
   logic [WIDTH_W-1:0]                    w2_d [NW2];
   logic [LENGHT_I-1:0][WIDTH_I-1:0]      reg_i_q, reg_i_d;
   logic [LENGHT_MID-1:0][WIDTH_MID-1:0]  mid_q, mid_d, mid_calc;
   logic [LENGHT_O-1:0][WIDTH_O-1:0]      reg_o_q, reg_o_d, out_calc;
   logic                                  armed_q, armed_d;
   logic                                  down_q, down_d;
   logic [WIDTH-1:0]                      out_d_q, out_d_d;
   logic [WIDTH-1:0]                      rd_data;
   logic                                  busy, wr_en, run_acc;
   int                                    addr_i;

   function automatic logic [SIG_W-1:0] hsig(input logic signed [SW-1:0] s);
      logic signed [SW-1:0] t;
      t = s + HALF;
      if (t < 0)
         return '0;
      else if (t > MAXV)
         return SIG_W'(MAXV);
      else
         return t[SIG_W-1:0];
   endfunction

   function automatic logic signed [SW-1:0] sext_w(input logic [WIDTH_W-1:0] w);
      return {{(SW-WIDTH_W){w[WIDTH_W-1]}}, w};
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < LENGHT_MID; gi++) begin : g_mid
         logic signed [SW-1:0] acc;
         always_comb begin
            acc = '0;
            for (int i = 0; i < LENGHT_I; i++)
               acc = acc + sext_w(w1_q[gi*LENGHT_I + i]) * $signed({{(SW-WIDTH_I){1'b0}}, reg_i_q[i]});
         end
         assign mid_calc[gi] = WIDTH_MID'(hsig(acc));
      end
      for (gi = 0; gi < LENGHT_O; gi++) begin : g_out
         logic signed [SW-1:0] acc;
         logic signed [SW-1:0] scaled;
         always_comb begin
            acc = '0;
            for (int j = 0; j < LENGHT_MID; j++)
               acc = acc + sext_w(w2_q[gi*LENGHT_MID + j]) * $signed({{(SW-WIDTH_MID){1'b0}}, mid_q[j]});
         end
         // Hidden activations carry a scale of RANGE_SIGM, removed before the output sigmoid.
         assign scaled        = acc >>> WIDTH_MID;
         assign out_calc[gi]  = WIDTH_O'(hsig(scaled));
      end
   endgenerate

   assign busy    = (state_q == S_CALC_MID) || (state_q == S_CALC_OUT);
   assign addr_i  = int'(address);
   assign wr_en   = write && !busy;
   assign run_acc = wr_en && (addr_i == A_RUN) && in_d[0] && armed_q;

   always_comb begin
      w1_d    = w1_q;
      w2_d    = w2_q;
      reg_i_d = reg_i_q;
      armed_d = armed_q;
      down_d  = down_q;
      state_d = state_q;
      mid_d   = mid_q;
      reg_o_d = reg_o_q;
      if (wr_en) begin
         for (int n = 0; n < NW1; n++)
            if (addr_i == n) w1_d[n] = WIDTH_W'(in_d);
         for (int n = 0; n < NW2; n++)
            if (addr_i == NW1 + n) w2_d[n] = WIDTH_W'(in_d);
         if (addr_i == A_CTRL) armed_d = in_d[0];
         for (int i = 0; i < LENGHT_I; i++) begin
            if (addr_i == A_IN + i) begin
               reg_i_d[i] = in_d[WIDTH_I-1:0];
               down_d     = 1'b0;
            end
         end
      end
      case (state_q)
         S_CALC_MID: begin
            mid_d   = mid_calc;
            state_d = S_CALC_OUT;
         end
         S_CALC_OUT: begin
            reg_o_d = out_calc;
            down_d  = 1'b1;
            state_d = S_DONE;
         end
         default: begin
            if (run_acc) begin
               down_d  = 1'b0;
               state_d = S_CALC_MID;
            end
         end
      endcase
   end

   always_comb begin
      rd_data = '0;
`ifdef FF_NET_READBACK_EN
      for (int n = 0; n < NW1; n++)
         if (addr_i == n) rd_data = WIDTH'(w1_q[n]);
      for (int n = 0; n < NW2; n++)
         if (addr_i == NW1 + n) rd_data = WIDTH'(w2_q[n]);
      for (int i = 0; i < LENGHT_I; i++)
         if (addr_i == A_IN + i) rd_data = WIDTH'(reg_i_q[i]);
`endif
      for (int k = 0; k < LENGHT_O; k++)
         if (addr_i == A_OUT + k) rd_data = WIDTH'(reg_o_q[k]);
      if (addr_i == A_STAT) rd_data = WIDTH'({down_q, ready});
      out_d_d = read ? rd_data : out_d_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         for (int n = 0; n < NW1; n++) w1_q[n] <= '0;
         for (int n = 0; n < NW2; n++) w2_q[n] <= '0;
         reg_i_q <= '0;
         mid_q   <= '0;
         reg_o_q <= '0;
         armed_q <= 1'b0;
         down_q  <= 1'b0;
         out_d_q <= '0;
      end else begin
         state_q <= state_d;
         for (int n = 0; n < NW1; n++) w1_q[n] <= w1_d[n];
         for (int n = 0; n < NW2; n++) w2_q[n] <= w2_d[n];
         reg_i_q <= reg_i_d;
         mid_q   <= mid_d;
         reg_o_q <= reg_o_d;
         armed_q <= armed_d;
         down_q  <= down_d;
         out_d_q <= out_d_d;
      end
   end

   assign ready      = armed_q && !busy;
   assign down       = down_q;
   assign out_d      = out_d_q;
   assign reg_i      = reg_i_q;
   assign mid_neiron = mid_q;
   assign reg_o      = reg_o_q;

endmodule

// File: tb/tb_ff_net_core.sv
// Directed bench for ff_net_core at default parameters; expected values are hand-computed.
module tb_ff_net_core;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [3:0]      in_d = '0;
   logic [3:0]      address = '0;
   logic            read = 1'b0;
   logic            write = 1'b0;
   logic [3:0]      out_d;
   logic            ready;
   logic            down;
   logic [1:0][0:0] reg_i;
   logic [1:0][3:0] mid_neiron;
   logic [1:0][3:0] reg_o;

   int checks = 0;
   int errors = 0;

   ff_net_core dut (
      .clk        (clk),
      .reset      (reset),
      .in_d       (in_d),
      .address    (address),
      .read       (read),
      .write      (write),
      .out_d      (out_d),
      .ready      (ready),
      .down       (down),
      .reg_i      (reg_i),
      .mid_neiron (mid_neiron),
      .reg_o      (reg_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic bus_write(input logic [3:0] a, input logic [3:0] d);
      @(negedge clk);
      address = a;
      in_d    = d;
      write   = 1'b1;
      @(posedge clk);
      #1;
      write   = 1'b0;
      $display("write addr=%0d data=%0h", a, d);
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [3:0] v);
      @(negedge clk);
      address = a;
      read    = 1'b1;
      @(posedge clk);
      #1;
      read    = 1'b0;
      v       = out_d;
      $display("read  addr=%0d data=%0h", a, v);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (reg_o !== 8'h00)      begin errors++; $display("FAIL reset_reg_o got=%h exp=00", reg_o); end
      checks++; if (mid_neiron !== 8'h00) begin errors++; $display("FAIL reset_mid got=%h exp=00", mid_neiron); end
      checks++; if (reg_i !== 2'b00)      begin errors++; $display("FAIL reset_reg_i got=%b exp=00", reg_i); end
      checks++; if (ready !== 1'b0)       begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
      checks++; if (down !== 1'b0)        begin errors++; $display("FAIL reset_down got=%b exp=0", down); end
      checks++; if (out_d !== 4'h0)       begin errors++; $display("FAIL reset_out_d got=%h exp=0", out_d); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_run_unarmed;
      for (int a = 0; a < 8; a++) bus_write(4'(a), 4'(a));
      bus_write(4'd9, 4'h0);
      bus_write(4'd10, 4'h1);
      bus_write(4'd11, 4'hF);
      repeat (3) @(posedge clk);
      #1;
      checks++; if (down !== 1'b0)        begin errors++; $display("FAIL unarmed_down got=%b exp=0", down); end
      checks++; if (reg_o !== 8'h00)      begin errors++; $display("FAIL unarmed_reg_o got=%h exp=00", reg_o); end
      checks++; if (mid_neiron !== 8'h00) begin errors++; $display("FAIL unarmed_mid got=%h exp=00", mid_neiron); end
      checks++; if (reg_i !== 2'b10)      begin errors++; $display("FAIL unarmed_reg_i got=%b exp=10", reg_i); end
      checks++; if (ready !== 1'b0)       begin errors++; $display("FAIL unarmed_ready got=%b exp=0", ready); end
   endtask

   task automatic test_basic_run;
      bus_write(4'd8, 4'hF);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL arm_ready got=%b exp=1", ready); end
      bus_write(4'd11, 4'hF);
      checks++; if (ready !== 1'b0)       begin errors++; $display("FAIL run_busy_ready got=%b exp=0", ready); end
      checks++; if (mid_neiron !== 8'h00) begin errors++; $display("FAIL run_mid_early got=%h exp=00", mid_neiron); end
      @(posedge clk); #1;
      checks++; if (mid_neiron !== 8'hB9) begin errors++; $display("FAIL run_mid got=%h exp=b9", mid_neiron); end
      checks++; if (reg_o !== 8'h00)      begin errors++; $display("FAIL run_reg_o_early got=%h exp=00", reg_o); end
      checks++; if (down !== 1'b0)        begin errors++; $display("FAIL run_down_early got=%b exp=0", down); end
      @(posedge clk); #1;
      checks++; if (reg_o !== 8'hFD)      begin errors++; $display("FAIL run_reg_o got=%h exp=fd", reg_o); end
      checks++; if (down !== 1'b1)        begin errors++; $display("FAIL run_down got=%b exp=1", down); end
      checks++; if (ready !== 1'b1)       begin errors++; $display("FAIL run_ready_done got=%b exp=1", ready); end
   endtask

   task automatic test_readback;
      logic [3:0] v;
      bus_read(4'd12, v);
      checks++; if (v !== 4'hD) begin errors++; $display("FAIL rd_out0 got=%h exp=d", v); end
      bus_read(4'd13, v);
      checks++; if (v !== 4'hF) begin errors++; $display("FAIL rd_out1 got=%h exp=f", v); end
      @(negedge clk);
      address = 4'd12;
      @(posedge clk); #1;
      checks++; if (out_d !== 4'hF) begin errors++; $display("FAIL rd_hold got=%h exp=f", out_d); end
      bus_read(4'd14, v);
      checks++; if (v !== 4'h3) begin errors++; $display("FAIL rd_status got=%h exp=3", v); end
      bus_read(4'd15, v);
      checks++; if (v !== 4'h0) begin errors++; $display("FAIL rd_unmapped got=%h exp=0", v); end
      bus_read(4'd3, v);
`ifdef FF_NET_READBACK_EN
      checks++; if (v !== 4'h3) begin errors++; $display("FAIL rd_weight got=%h exp=3", v); end
`else
      checks++; if (v !== 4'h0) begin errors++; $display("FAIL rd_weight got=%h exp=0", v); end
`endif
      bus_write(4'd9, 4'h0);
      checks++; if (down !== 1'b0) begin errors++; $display("FAIL input_clears_down got=%b exp=0", down); end
      bus_read(4'd14, v);
      checks++; if (v !== 4'h1) begin errors++; $display("FAIL rd_status2 got=%h exp=1", v); end
   endtask

   task automatic test_busy_write;
      bus_write(4'd11, 4'hF);
      bus_write(4'd1, 4'h7);
      checks++; if (mid_neiron !== 8'hB9) begin errors++; $display("FAIL busy_mid got=%h exp=b9", mid_neiron); end
      @(posedge clk); #1;
      checks++; if (reg_o !== 8'hFD) begin errors++; $display("FAIL busy_reg_o got=%h exp=fd", reg_o); end
      checks++; if (down !== 1'b1)   begin errors++; $display("FAIL busy_down got=%b exp=1", down); end
      bus_write(4'd11, 4'hF);
      checks++; if (down !== 1'b0)   begin errors++; $display("FAIL rerun_clears_down got=%b exp=0", down); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (mid_neiron !== 8'hB9) begin errors++; $display("FAIL rerun_mid got=%h exp=b9", mid_neiron); end
      checks++; if (reg_o !== 8'hFD)      begin errors++; $display("FAIL rerun_reg_o got=%h exp=fd", reg_o); end
   endtask

   task automatic test_reset_mid_run;
      bus_write(4'd11, 4'hF);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      checks++; if (reg_o !== 8'h00)      begin errors++; $display("FAIL rst_run_reg_o got=%h exp=00", reg_o); end
      checks++; if (down !== 1'b0)        begin errors++; $display("FAIL rst_run_down got=%b exp=0", down); end
      checks++; if (mid_neiron !== 8'h00) begin errors++; $display("FAIL rst_run_mid got=%h exp=00", mid_neiron); end
      checks++; if (ready !== 1'b0)       begin errors++; $display("FAIL rst_run_ready got=%b exp=0", ready); end
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (down !== 1'b0)   begin errors++; $display("FAIL rst_after_down got=%b exp=0", down); end
      checks++; if (reg_o !== 8'h00) begin errors++; $display("FAIL rst_after_reg_o got=%h exp=00", reg_o); end
   endtask

   initial begin
      test_reset();
      test_run_unarmed();
      test_basic_run();
      test_readback();
      test_busy_write();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
